secure_uart_tx_serializer: RTL and testbench
============================================

// Module: secure_uart_tx_serializer
// PURPOSE
//  Serial transmit stage upstream of the secure RX top: buffers ciphertext bytes from the TX-side Trivium
//  encryptor in a FIFO and serialises them as 16550-style frames on tx_o.
//  tx_o drives the far end's rx_i. Frame format comes from the shared UART LCR fields and the 16x baud_pulse.
// PARAMETERS
//  FIFO_AW     4    FIFO address width; depth = 2**FIFO_AW bytes
//  OVERSAMPLE  16   baud_pulse ticks per bit period (power of two, >=4)
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  n_rst          in   1  synchronous reset, active low
//  baud_pulse     in   1  one-cycle 16x-oversample tick from the baud generator
//  wls            in   2  word length: 00=5, 01=6, 10=7, 11=8 data bits
//  stb            in   1  0 = 1 stop bit; 1 = 1.5 stop (5-bit word) or 2 stop (otherwise)
//  pen            in   1  parity enable
//  eps            in   1  1 = even parity, 0 = odd parity
//  sticky_parity  in   1  1 = parity bit forced to ~eps (requires pen)
//  fifo_clr_i     in   1  flush FIFO; does not abort the frame in flight
//  push_i         in   1  write din_i into the FIFO
//  din_i          in   8  ciphertext byte; bits above the word length are ignored on the wire
//  fifo_full_o    out  1  FIFO holds 2**FIFO_AW bytes
//  fifo_empty_o   out  1  FIFO holds 0 bytes (THRE)
//  tx_empty_o     out  1  FIFO empty AND FSM in S_IDLE (TEMT)
//  ovf_o          out  1  one-cycle pulse: push_i dropped because the FIFO was full
//  tx_o           out  1  serial line, idle high
// BEHAVIOUR
//  Reset values:
//   - tx_o=1, fifo_empty_o=1, tx_empty_o=1, fifo_full_o=0, ovf_o=0
//   - FSM in S_IDLE, tick and bit counters 0, FIFO pointers 0
//  FIFO:
//   - Registered pointers plus a count of FIFO_AW+1 bits.
//   - Push when full: dropped, ovf_o=1 next cycle.
//   - Push and pop in the same cycle while full: both succeed, count unchanged.
//   - Push while empty: data becomes visible to the FSM the following cycle; no fall-through.
//   - fifo_clr_i has priority over push_i in the same cycle; pointers and count go to 0.
//  FSM states: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
//   - Each state advances only on baud_pulse. A 4-bit tick counter counts OVERSAMPLE ticks per bit.
//   - S_IDLE -> S_START on a baud_pulse cycle with FIFO non-empty:
//       - pop the FIFO head into the shift register
//       - latch wls/stb/pen/eps/sticky_parity for the whole frame
//       - tx_o falls to 0 on the next clock edge
//   - S_START: OVERSAMPLE ticks, then S_DATA.
//   - S_DATA: LSB first, one bit per OVERSAMPLE ticks, 5+wls bits.
//       - After the last bit, go to S_PARITY if pen, else S_STOP.
//   - S_PARITY: OVERSAMPLE ticks.
//       - Normal: bit = ^data[word] ^ ~eps (even gives an even total of ones).
//       - Sticky: bit = ~eps.
//   - S_STOP: tx_o=1 for OVERSAMPLE ticks (stb=0), OVERSAMPLE*3/2 (stb=1, 5-bit) or 2*OVERSAMPLE (stb=1).
//       - Then S_START directly if the FIFO is non-empty (pop on that same baud_pulse), else S_IDLE.
//       - Back-to-back frames have no idle gap.
//  Other rules:
//   - tx_o is a registered output, never glitching.
//   - Config changes mid-frame have no effect until the next frame start.
//   - Reset mid-frame: tx_o=1 on the next clock, partial frame abandoned, FIFO emptied.
// CONFIGURATION
//  UART_TX_BREAK_EN defined:
//   - Adds input set_break (1 bit, LCR[6]).
//   - While set_break=1, tx_o=0 regardless of FSM state; the FSM keeps running (16550 semantics).
//   - On release, tx_o follows the FSM on the next clock.
//  UART_TX_BREAK_EN undefined: no set_break port; tx_o is driven only by the FSM.
// TESTING
//  T1 8N1, baud_pulse every cycle, push 0x55:
//     - tx_o: 16 cyc 0, then 1,0,1,0,1,0,1,0 at 16 cyc each, then 16 cyc 1
//     - tx_empty_o returns to 1 after 160 baud ticks
//  T2 7E2 (wls=10, pen=1, eps=1, stb=1), push 0xFF:
//     - data 1111111, parity 1, 32 ticks stop; bit 7 never sent
//  T3 sticky parity (pen=1, eps=0, sticky_parity=1), 5 bits, stb=1, push 0x00:
//     - 5 zeros, parity 1, stop 24 ticks
//  T4 push 2**FIFO_AW+1 bytes with baud_pulse held low:
//     - fifo_full_o=1, one ovf_o pulse
//     - then frames 0..15 sent back-to-back with no idle ticks between stop and start
//  T5 reset and flush:
//     - n_rst=0 during S_DATA of 0xA3: tx_o=1 next cycle, all flags return to reset values
//     - fifo_clr_i with push_i same cycle: FIFO empty
//  T6 (UART_TX_BREAK_EN) set_break=1 for 40 ticks mid-frame:
//     - tx_o=0 throughout; frame timing counters unaffected

Source files
------------

// File: rtl/secure_uart_tx_serializer.sv
// secure_uart_tx_serializer: byte FIFO feeding a 16550-style serial frame generator on tx_o.
// Define UART_TX_BREAK_EN to add the set_break input (forces the line low while the FSM keeps running).
module secure_uart_tx_serializer #(
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       baud_pulse,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
`ifdef UART_TX_BREAK_EN
    input  logic       set_break,
`endif
    input  logic       fifo_clr_i,
    input  logic       push_i,
    input  logic [7:0] din_i,
    output logic       fifo_full_o,
    output logic       fifo_empty_o,
    output logic       tx_empty_o,
    output logic       ovf_o,
    output logic       tx_o
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned TW    = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic               do_push;
    logic               pop;

    state_t        state;
    logic [TW-1:0] tick;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_q;
    logic [1:0]    wls_q;
    logic          stb_q;
    logic          pen_q;

    logic [7:0] head;
    logic [7:0] head_masked;
    logic       head_par;
    logic       tick_last;
    logic       stop_done;
    logic       line_cur;

    assign fifo_empty_o = (count == '0);
    assign fifo_full_o  = (count == CW'(DEPTH));
    assign tx_empty_o   = fifo_empty_o && (state == S_IDLE);

    // Line level the FSM is currently holding; break (if built in) is applied on top.
    function automatic logic drive(input logic v);
`ifdef UART_TX_BREAK_EN
        return v & ~set_break;
`else
        return v;
`endif
    endfunction

    always_comb begin
        head        = mem[rd_ptr];
        head_masked = head & (8'hFF >> (2'd3 - wls));
        head_par    = sticky_parity ? ~eps : ((^head_masked) ^ ~eps);
        tick_last   = (tick == TICK_LAST);
        stop_done   = 1'b0;
        if (!stb_q)
            stop_done = tick_last;
        else if (bit_cnt != 3'd0)
            stop_done = (wls_q == 2'd0) ? (tick == TICK_HALF) : tick_last;
        line_cur = 1'b1;
        case (state)
            S_START:  line_cur = 1'b0;
            S_DATA:   line_cur = shreg[0];
            S_PARITY: line_cur = par_q;
            default:  line_cur = 1'b1;
        endcase
        pop     = baud_pulse && !fifo_empty_o &&
                  ((state == S_IDLE) || ((state == S_STOP) && stop_done));
        do_push = n_rst && push_i && !fifo_clr_i && (!fifo_full_o || pop);
    end

    // FIFO pointers and occupancy; clear beats push in the same cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            ovf_o <= push_i && fifo_full_o && !pop && !fifo_clr_i;
            if (fifo_clr_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
                if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
                if (do_push && !pop)
                    count <= count + CW'(1);
                else if (!do_push && pop)
                    count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

    // Frame FSM; every transition waits for baud_pulse, tx_o is registered alongside.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            tx_o    <= 1'b1;
        end else begin
            tx_o <= drive(line_cur);
            if (pop) begin
                state   <= S_START;
                tick    <= '0;
                bit_cnt <= '0;
                shreg   <= head_masked;
                par_q   <= head_par;
                wls_q   <= wls;
                stb_q   <= stb;
                pen_q   <= pen;
                tx_o    <= drive(1'b0);
            end else if (baud_pulse) begin
                case (state)
                    S_START: begin
                        if (tick_last) begin
                            tick  <= '0;
                            state <= S_DATA;
                            tx_o  <= drive(shreg[0]);
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    S_DATA: begin
                        if (tick_last) begin
                            tick <= '0;
                            if (bit_cnt == ({1'b0, wls_q} + 3'd4)) begin
                                bit_cnt <= '0;
                                if (pen_q) begin
                                    state <= S_PARITY;
                                    tx_o  <= drive(par_q);
                                end else begin
                                    state <= S_STOP;
                                    tx_o  <= drive(1'b1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                                tx_o    <= drive(shreg[1]);
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (tick_last) begin
                            tick  <= '0;
                            state <= S_STOP;
                            tx_o  <= drive(1'b1);
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    S_STOP: begin
                        if (stop_done) begin
                            tick    <= '0;
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                            tx_o    <= drive(1'b1);
                        end else if (tick_last) begin
                            tick    <= '0;
                            bit_cnt <= bit_cnt + 3'd1;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    S_IDLE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_secure_uart_tx_serializer.sv
// Randomized bench for secure_uart_tx_serializer against a queue-based model of line levels per baud tick.
// Builds with or without UART_TX_BREAK_EN.
module tb_secure_uart_tx_serializer;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       baud_pulse = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic       fifo_clr_i = 1'b0;
    logic       push_i = 1'b0;
    logic [7:0] din_i = 8'h00;
`ifdef UART_TX_BREAK_EN
    logic       brk = 1'b0;
`endif
    logic fifo_full_o, fifo_empty_o, tx_empty_o, ovf_o, tx_o;

    secure_uart_tx_serializer dut (
        .clk(clk), .n_rst(n_rst), .baud_pulse(baud_pulse),
        .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sticky_parity(sticky_parity),
`ifdef UART_TX_BREAK_EN
        .set_break(brk),
`endif
        .fifo_clr_i(fifo_clr_i), .push_i(push_i), .din_i(din_i),
        .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o), .tx_empty_o(tx_empty_o),
        .ovf_o(ovf_o), .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: pending bytes, and the line level expected after each remaining baud tick of the frame.
    logic [7:0] mq[$];
    logic       fq[$];
    logic       busy = 1'b0;
    logic       m_line = 1'b1;
    logic       m_ovf = 1'b0;
    logic       m_brk = 1'b0;
    logic       started = 1'b0;

    task automatic build_frame(input logic [7:0] b);
        int nb;
        int ones;
        int stop_ticks;
        logic p;
        nb   = 5 + int'(wls);
        ones = 0;
        repeat (16) fq.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            ones += int'(b[i]);
            repeat (16) fq.push_back(b[i]);
        end
        if (pen) begin
            if (sticky_parity) p = !eps;
            else if (eps)      p = ((ones % 2) == 1);
            else               p = ((ones % 2) == 0);
            repeat (16) fq.push_back(p);
        end
        stop_ticks = !stb ? 16 : ((wls == 2'd0) ? 24 : 32);
        repeat (stop_ticks) fq.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (!n_rst) begin
            mq.delete();
            fq.delete();
            busy   = 1'b0;
            m_line = 1'b1;
            m_ovf  = 1'b0;
            m_brk  = 1'b0;
        end else begin
            if (baud_pulse) begin
                if (fq.size() == 0) begin
                    busy = 1'b0;
                    if (mq.size() != 0) begin
                        build_frame(mq.pop_front());
                        busy = 1'b1;
                    end
                end
                if (fq.size() != 0) m_line = fq.pop_front();
                else                m_line = 1'b1;
            end
            m_ovf = 1'b0;
            if (fifo_clr_i) mq.delete();
            else if (push_i) begin
                if (mq.size() < DEPTH) mq.push_back(din_i);
                else                   m_ovf = 1'b1;
            end
`ifdef UART_TX_BREAK_EN
            m_brk = brk;
`endif
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("tx_o",  32'(tx_o),         32'(m_line & ~m_brk));
            chk("empty", 32'(fifo_empty_o), 32'(mq.size() == 0));
            chk("full",  32'(fifo_full_o),  32'(mq.size() == DEPTH));
            chk("temt",  32'(tx_empty_o),   32'((mq.size() == 0) && !busy));
            chk("ovf",   32'(ovf_o),        32'(m_ovf));
        end
    end

    int unsigned baud_pct = 100;

    task automatic cycle(input logic p, input logic [7:0] d, input logic c);
        @(negedge clk);
        push_i     = p;
        din_i      = d;
        fifo_clr_i = c;
        baud_pulse = ($urandom_range(99) < baud_pct);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic s, input logic p, input logic e, input logic st);
        wls = w; stb = s; pen = p; eps = e; sticky_parity = st;
    endtask

    task automatic wait_temt(input int maxc, output int k);
        k = 0;
        do begin
            cycle(1'b0, 8'h00, 1'b0);
            k++;
        end while (!tx_empty_o && k < maxc);
    endtask

    initial begin
        int k;
        int ovf_cnt;
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        n_rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);

        // 8N1, one byte: start + 8 data + stop = 160 ticks after the pop
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_pct = 100;
        cycle(1'b1, 8'h55, 1'b0);
        wait_temt(400, k);
        chk("t1_temt_cycles", 32'(k), 32'd162);

        // 7E2, 0xFF: 16 + 7*16 + 16 + 32 = 176 ticks
        set_cfg(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        wait_temt(400, k);
        chk("t2_temt_cycles", 32'(k), 32'd178);

        // 5-bit sticky parity, 1.5 stop: 16 + 80 + 16 + 24 = 136 ticks
        set_cfg(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        wait_temt(400, k);
        chk("t3_temt_cycles", 32'(k), 32'd138);

        // Overfill with no baud ticks, then drain 16 frames back to back
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_pct = 0;
        ovf_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 8'(i * 13 + 1), 1'b0);
            if (ovf_o) ovf_cnt++;
        end
        cycle(1'b0, 8'h00, 1'b0);
        if (ovf_o) ovf_cnt++;
        chk("t4_full", 32'(fifo_full_o), 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        if (ovf_o) ovf_cnt++;
        chk("t4_ovf_pulses", 32'(ovf_cnt), 32'd1);
        baud_pct = 100;
        wait_temt(3000, k);
        chk("t4_drain_cycles", 32'(k), 32'd2562);

        // Reset in the middle of a data bit, then clear racing a push
        cycle(1'b1, 8'hA3, 1'b0);
        repeat (40) cycle(1'b0, 8'h00, 1'b0);
        n_rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        chk("t5_rst_tx", 32'(tx_o), 32'd1);
        chk("t5_rst_temt", 32'(tx_empty_o), 32'd1);
        n_rst = 1'b1;
        baud_pct = 0;
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t5_clr_empty", 32'(fifo_empty_o), 32'd1);

`ifdef UART_TX_BREAK_EN
        // Break mid-frame must not disturb frame timing
        baud_pct = 100;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0);
        repeat (30) cycle(1'b0, 8'h00, 1'b0);
        brk = 1'b1;
        repeat (40) cycle(1'b0, 8'h00, 1'b0);
        brk = 1'b0;
        wait_temt(400, k);
        chk("t6_temt_cycles", 32'(k), 32'd92);
`endif

        // Random traffic, sparse baud ticks, mid-frame config changes, rare clears and resets
        for (int s = 0; s < 40; s++) begin
            baud_pct = $urandom_range(100, 20);
            set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(99) < 3)
                    set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`ifdef UART_TX_BREAK_EN
                if ($urandom_range(99) == 0) brk = ~brk;
`endif
                cycle($urandom_range(99) < 4, 8'($urandom), $urandom_range(999) < 2);
                n_rst = ($urandom_range(2999) != 0);
            end
        end
        n_rst = 1'b1;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        baud_pct = 100;
        wait_temt(8000, k);
        chk("final_drain", 32'(tx_empty_o), 32'd1);
        repeat (4) cycle(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
